// File: rtl/sector_read_ctrl_pkg.sv
// Shared floppy definitions: completion status codes, address-mark bytes,
// the largest legal ID size code, the CRC preset and a helper that turns a
// size code into the last payload byte offset.
package sector_read_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OK        = 3'd0,
    ST_NOT_FOUND = 3'd1,
    ST_NO_DAM    = 3'd2,
    ST_CRC_ERR   = 3'd3,
    ST_BAD_SIZE  = 3'd4,
    ST_ABORTED   = 3'd5
  } status_e;

  localparam logic [7:0]  MARK_A1  = 8'hA1;
  localparam logic [7:0]  MARK_FE  = 8'hFE;
  localparam logic [7:0]  MARK_FB  = 8'hFB;
  localparam logic [7:0]  MARK_F8  = 8'hF8;
  localparam logic [7:0]  SIZE_MAX = 8'd3;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // (128 << sz) - 1; size 3 gives 1023, the top of the 10-bit byte counter.
  function automatic logic [9:0] sector_last(input logic [1:0] sz);
    logic [10:0] n;
    n = 11'd128 << sz;
    return 10'(n - 11'd1);
  endfunction

endpackage

// File: rtl/sector_read_ctrl_if.sv
// Host side of the sector read controller.
//   request : i_Req, i_ReqTrack/Side/Sector, i_Abort (host -> controller)
//   stream  : o_Data, o_DataValid, o_ByteIndex     (controller -> host)
//   status  : o_Busy, o_Done, o_Status, o_Deleted  (controller -> host)
interface sector_read_ctrl_if;
  logic       i_Req;
  logic [7:0] i_ReqTrack;
  logic [7:0] i_ReqSide;
  logic [7:0] i_ReqSector;
  logic       i_Abort;
  logic       o_Busy;
  logic [7:0] o_Data;
  logic       o_DataValid;
  logic [9:0] o_ByteIndex;
  logic       o_Done;
  logic [2:0] o_Status;
  logic       o_Deleted;

  modport master (
    output i_Req, i_ReqTrack, i_ReqSide, i_ReqSector, i_Abort,
    input  o_Busy, o_Data, o_DataValid, o_ByteIndex, o_Done, o_Status, o_Deleted
  );

  modport slave (
    input  i_Req, i_ReqTrack, i_ReqSide, i_ReqSector, i_Abort,
    output o_Busy, o_Data, o_DataValid, o_ByteIndex, o_Done, o_Status, o_Deleted
  );
endinterface

// File: rtl/crc16_ccitt_byte.sv
// One byte step of CRC-16-CCITT (poly 0x1021, MSB first), combinational.
//   crc_in  : running CRC
//   data    : byte to fold in
//   crc_out : updated CRC
module crc16_ccitt_byte (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);
  logic [7:0]  t;
  logic [7:0]  x;
  logic [15:0] xw;

  // Table-free byte form: the eight shift/xor steps collapse into three
  // shifted copies of the folded top byte.
  always_comb begin
    t       = crc_in[15:8] ^ data;
    x       = t ^ {4'h0, t[7:4]};
    xw      = {8'h00, x};
    crc_out = {crc_in[7:0], 8'h00} ^ (xw << 12) ^ (xw << 5) ^ xw;
  end
endmodule

// File: rtl/sector_read_ctrl.sv
// Floppy sector read sequencer: hunts for a matching ID header, finds the
// data address mark inside a bounded gap, streams the payload, checks CRC
// and reports a status with a one-cycle o_Done.
//   i_Clk, i_Reset      : clock, async active-high reset
//   host                : request / payload stream / status (slave modport)
//   i_Index             : one-cycle index pulse
//   i_Sync/i_Data/i_Valid : MFM byte stream
//   i_Hdr*              : CRC-good ID field from the header parser
// Build option: SECTOR_READ_DELETED_EN accepts the F8 (deleted) data mark.
module sector_read_ctrl
  import sector_read_ctrl_pkg::*;
#(
  parameter int MAX_REVS  = 2,
  parameter int GAP_BYTES = 64
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  sector_read_ctrl_if.slave host,
  input  logic       i_Index,
  input  logic       i_Sync,
  input  logic [7:0] i_Data,
  input  logic       i_Valid,
  input  logic       i_HdrValid,
  input  logic [7:0] i_HdrTrack,
  input  logic [7:0] i_HdrSide,
  input  logic [7:0] i_HdrSector,
  input  logic [7:0] i_HdrSize
);
  localparam int GW = $clog2(GAP_BYTES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HUNT, S_DAM_SYNC, S_DAM_A1, S_DAM_MARK,
    S_DATA, S_CRC_HI, S_CRC_LO, S_CHECK
  } state_t;

  state_t        state;
  logic [7:0]    req_trk, req_side, req_sec;
  logic [1:0]    size_q;
  logic [3:0]    idx_cnt, idx_nxt;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    a1_cnt;
  logic [9:0]    byte_cnt;
  logic          no_dam;
  logic [15:0]   crc, crc_nxt, rd_crc;
  logic          busy_q, done_q, dvalid_q;
  logic [7:0]    data_q;
  logic [9:0]    bidx_q;
  status_e       status_q;
  logic          hdr_match, rev_limit;
`ifdef SECTOR_READ_DELETED_EN
  logic          deleted_q;
`endif

  crc16_ccitt_byte u_crc (.crc_in(crc), .data(i_Data), .crc_out(crc_nxt));

  assign hdr_match = i_HdrValid && (i_HdrTrack == req_trk) &&
                     (i_HdrSide == req_side) && (i_HdrSector == req_sec);
  // Limit is judged on the post-pulse count so termination lands the cycle
  // right after the final index pulse.
  assign idx_nxt   = (i_Index && idx_cnt != 4'(MAX_REVS)) ? idx_cnt + 4'd1 : idx_cnt;
  assign rev_limit = (idx_nxt == 4'(MAX_REVS));

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state    <= S_IDLE;
      req_trk  <= '0;
      req_side <= '0;
      req_sec  <= '0;
      size_q   <= '0;
      idx_cnt  <= '0;
      gap_cnt  <= '0;
      a1_cnt   <= '0;
      byte_cnt <= '0;
      no_dam   <= 1'b0;
      crc      <= CRC_INIT;
      rd_crc   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dvalid_q <= 1'b0;
      data_q   <= '0;
      bidx_q   <= '0;
      status_q <= ST_OK;
`ifdef SECTOR_READ_DELETED_EN
      deleted_q <= 1'b0;
`endif
    end else begin
      done_q   <= 1'b0;
      dvalid_q <= 1'b0;
      if (state != S_IDLE) idx_cnt <= idx_nxt;

      if (state != S_IDLE && host.i_Abort) begin
        state    <= S_IDLE;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        status_q <= ST_ABORTED;
      end else begin
        case (state)
          S_IDLE: begin
            // done_q high means we left CHECK this very cycle; drop the request.
            if (host.i_Req && !done_q) begin
              req_trk  <= host.i_ReqTrack;
              req_side <= host.i_ReqSide;
              req_sec  <= host.i_ReqSector;
              idx_cnt  <= '0;
              gap_cnt  <= '0;
              byte_cnt <= '0;
              no_dam   <= 1'b0;
              status_q <= ST_OK;
`ifdef SECTOR_READ_DELETED_EN
              deleted_q <= 1'b0;
`endif
              busy_q   <= 1'b1;
              state    <= S_HUNT;
            end
          end
          S_HUNT: begin
            if (rev_limit) begin
              state    <= S_IDLE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              status_q <= no_dam ? ST_NO_DAM : ST_NOT_FOUND;
            end else if (hdr_match) begin
              if (i_HdrSize > SIZE_MAX) begin
                state    <= S_IDLE;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                status_q <= ST_BAD_SIZE;
              end else begin
                size_q  <= i_HdrSize[1:0];
                gap_cnt <= '0;
                state   <= S_DAM_SYNC;
              end
            end
          end
          S_DAM_SYNC: begin
            if (rev_limit) begin
              state    <= S_IDLE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              status_q <= no_dam ? ST_NO_DAM : ST_NOT_FOUND;
            end else if (i_Sync) begin
              crc    <= CRC_INIT;
              a1_cnt <= '0;
              state  <= S_DAM_A1;
            end else if (i_Valid) begin
              if (gap_cnt == GW'(GAP_BYTES - 1)) begin
                no_dam <= 1'b1;
                state  <= S_HUNT;
              end else begin
                gap_cnt <= gap_cnt + GW'(1);
              end
            end
          end
          S_DAM_A1: begin
            if (i_Valid) begin
              crc <= crc_nxt;
              if (i_Data != MARK_A1) begin
                no_dam <= 1'b1;
                state  <= S_HUNT;
              end else if (a1_cnt == 2'd2) begin
                state <= S_DAM_MARK;
              end else begin
                a1_cnt <= a1_cnt + 2'd1;
              end
            end
          end
          S_DAM_MARK: begin
            if (i_Valid) begin
              crc      <= crc_nxt;
              byte_cnt <= '0;
              if (i_Data == MARK_FB) begin
                state <= S_DATA;
`ifdef SECTOR_READ_DELETED_EN
              end else if (i_Data == MARK_F8) begin
                deleted_q <= 1'b1;
                state     <= S_DATA;
`endif
              end else begin
                no_dam <= 1'b1;
                state  <= S_HUNT;
              end
            end
          end
          S_DATA: begin
            if (i_Valid) begin
              crc      <= crc_nxt;
              data_q   <= i_Data;
              dvalid_q <= 1'b1;
              bidx_q   <= byte_cnt;
              if (byte_cnt == sector_last(size_q)) state <= S_CRC_HI;
              else byte_cnt <= byte_cnt + 10'd1;
            end
          end
          S_CRC_HI: if (i_Valid) begin
            rd_crc[15:8] <= i_Data;
            state        <= S_CRC_LO;
          end
          S_CRC_LO: if (i_Valid) begin
            rd_crc[7:0] <= i_Data;
            state       <= S_CHECK;
          end
          S_CHECK: begin
            state    <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            status_q <= (crc == rd_crc) ? ST_OK : ST_CRC_ERR;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign host.o_Busy      = busy_q;
  assign host.o_Done      = done_q;
  assign host.o_Data      = data_q;
  assign host.o_DataValid = dvalid_q;
  assign host.o_ByteIndex = bidx_q;
  assign host.o_Status    = status_q;
`ifdef SECTOR_READ_DELETED_EN
  assign host.o_Deleted   = deleted_q;
`else
  assign host.o_Deleted   = 1'b0;
`endif
endmodule

// File: tb/tb_sector_read_ctrl.sv
// Scoreboard bench for sector_read_ctrl: stimulus pushes the expected payload
// bytes and completion records; a negedge monitor pops and compares.
module tb_sector_read_ctrl;
  import sector_read_ctrl_pkg::*;

  localparam int MAX_REVS  = 2;
  localparam int GAP_BYTES = 64;

  logic       i_Clk = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Index = 1'b0, i_Sync = 1'b0, i_Valid = 1'b0, i_HdrValid = 1'b0;
  logic [7:0] i_Data = '0, i_HdrTrack = '0, i_HdrSide = '0, i_HdrSector = '0, i_HdrSize = '0;

  sector_read_ctrl_if hif();

  sector_read_ctrl #(.MAX_REVS(MAX_REVS), .GAP_BYTES(GAP_BYTES)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .host(hif), .i_Index(i_Index),
    .i_Sync(i_Sync), .i_Data(i_Data), .i_Valid(i_Valid),
    .i_HdrValid(i_HdrValid), .i_HdrTrack(i_HdrTrack), .i_HdrSide(i_HdrSide),
    .i_HdrSector(i_HdrSector), .i_HdrSize(i_HdrSize)
  );

  always #5 i_Clk = ~i_Clk;

  int cyc = 0;
  always @(posedge i_Clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; logic [9:0] idx; } dexp_t;
  typedef struct { logic [2:0] st; logic del; int at; } rexp_t;
  dexp_t dq[$];
  rexp_t rq[$];
  int vectors = 0, errors = 0;

  always @(negedge i_Clk) begin : mon
    dexp_t de;
    rexp_t re;
    if (!i_Reset) begin
      if (hif.o_DataValid) begin
        vectors++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL data_extra: idx=%0d data=%h, none expected", hif.o_ByteIndex, hif.o_Data);
        end else begin
          de = dq.pop_front();
          if (hif.o_Data !== de.d || hif.o_ByteIndex !== de.idx) begin
            errors++;
            $display("FAIL data: idx %0d want %0d, data %h want %h",
                     hif.o_ByteIndex, de.idx, hif.o_Data, de.d);
          end
        end
      end
      if (hif.o_Done) begin
        vectors++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL done_extra: status=%0d at cycle %0d, none expected", hif.o_Status, cyc);
        end else begin
          re = rq.pop_front();
          if (hif.o_Status !== re.st || hif.o_Deleted !== re.del || cyc != re.at || hif.o_Busy !== 1'b0) begin
            errors++;
            $display("FAIL done: status %0d want %0d, deleted %b want %b, cycle %0d want %0d, busy %b want 0",
                     hif.o_Status, re.st, hif.o_Deleted, re.del, cyc, re.at, hif.o_Busy);
          end
        end
      end
    end
  end

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge i_Clk); #1;
  endtask

  task automatic start(input logic [7:0] t, input logic [7:0] s, input logic [7:0] r);
    hif.i_ReqTrack = t; hif.i_ReqSide = s; hif.i_ReqSector = r;
    hif.i_Req = 1'b1; tick(); hif.i_Req = 1'b0;
    @(negedge i_Clk);
    vectors++;
    if (hif.o_Busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start: busy %b want 1", hif.o_Busy);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit jitter);
    i_Data = b; i_Valid = 1'b1; tick(); i_Valid = 1'b0;
    if (jitter && $urandom_range(0, 3) == 0) tick();
  endtask

  task automatic hdr(input logic [7:0] t, input logic [7:0] s, input logic [7:0] r, input logic [7:0] z);
    i_HdrTrack = t; i_HdrSide = s; i_HdrSector = r; i_HdrSize = z;
    i_HdrValid = 1'b1; tick(); i_HdrValid = 1'b0;
  endtask

  task automatic sync_pulse();
    i_Sync = 1'b1; tick(); i_Sync = 1'b0;
  endtask

  task automatic idx_pulse();
    i_Index = 1'b1; tick(); i_Index = 1'b0;
  endtask

  task automatic check_reset_state(input string nm);
    @(negedge i_Clk);
    vectors++;
    if ({hif.o_Busy, hif.o_Done, hif.o_DataValid, hif.o_Deleted} !== 4'b0 ||
        hif.o_Status !== 3'd0 || hif.o_ByteIndex !== 10'd0 || hif.o_Data !== 8'd0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b dv=%b del=%b st=%0d idx=%0d data=%h, want all 0", nm,
               hif.o_Busy, hif.o_Done, hif.o_DataValid, hif.o_Deleted, hif.o_Status,
               hif.o_ByteIndex, hif.o_Data);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && rq.size() != 0; i++) tick();
    vectors++;
    if (rq.size() != 0) begin
      errors++;
      $display("FAIL done_timeout: %0d completions outstanding, want 0", rq.size());
      rq.delete();
    end
    vectors++;
    if (dq.size() != 0) begin
      errors++;
      $display("FAIL data_missing: %0d bytes never streamed, want 0", dq.size());
      dq.delete();
    end
    tick();
  endtask

  // One complete read: decoy headers, gap, DAM, payload, CRC.
  task automatic read_sector(input logic [7:0] t, input logic [7:0] s, input logic [7:0] r,
                             input int sz, input int ngap, input bit corrupt,
                             input logic [7:0] mark, input bit req_at_done);
    logic [15:0] c;
    logic [7:0]  b;
    int          n, flip;
    start(t, s, r);
    repeat ($urandom_range(0, 3)) hdr(t, s, 8'(r + 1 + $urandom_range(0, 5)), 8'(sz));
    hdr(8'(t + 1), s, r, 8'(sz));
    hdr(t, 8'(s + 1), r, 8'(sz));
    hdr(t, s, r, 8'(sz));
    for (int i = 0; i < ngap; i++) begin
      send_byte(8'($urandom), 1'b1);
      if (i == ngap / 2) begin
        hif.i_ReqTrack = 8'($urandom); hif.i_ReqSector = 8'($urandom);
        hif.i_Req = 1'b1; tick(); hif.i_Req = 1'b0;
      end
    end
    sync_pulse();
    c = CRC_INIT;
    for (int i = 0; i < 4; i++) begin
      b = (i < 3) ? MARK_A1 : mark;
      c = crc_upd(c, b);
      send_byte(b, 1'b1);
    end
    n = 128 << sz;
    flip = corrupt ? int'($urandom_range(0, n - 1)) : -1;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      c = crc_upd(c, b);
      if (i == flip) b = b ^ 8'h10;
      dq.push_back('{b, 10'(i)});
      send_byte(b, 1'b1);
    end
    send_byte(c[15:8], 1'b1);
    send_byte(c[7:0], 1'b0);
    rq.push_back('{corrupt ? 3'd3 : 3'd0, mark == MARK_F8, cyc + 1});
    if (req_at_done) begin
      tick();
      hif.i_Req = 1'b1; tick(); hif.i_Req = 1'b0;
      @(negedge i_Clk);
      vectors++;
      if (hif.o_Busy !== 1'b0) begin
        errors++;
        $display("FAIL req_at_done: busy %b want 0", hif.o_Busy);
      end
    end
    wait_idle();
  endtask

  initial begin
    hif.i_Req = 1'b0; hif.i_Abort = 1'b0;
    hif.i_ReqTrack = '0; hif.i_ReqSide = '0; hif.i_ReqSector = '0;
    repeat (3) @(posedge i_Clk);
    check_reset_state("reset_held");
    tick(); i_Reset = 1'b0;
    tick();
    check_reset_state("reset_released");

    read_sector(8'd5, 8'd0, 8'd3, 2, 22, 1'b0, MARK_FB, 1'b1);
    read_sector(8'd5, 8'd0, 8'd3, 2, 22, 1'b1, MARK_FB, 1'b0);
    read_sector(8'd9, 8'd1, 8'd7, 0, GAP_BYTES - 1, 1'b0, MARK_FB, 1'b0);

    // Sector absent: NOT_FOUND the cycle after the last index pulse.
    start(8'd5, 8'd0, 8'd9);
    for (int r = 1; r <= 8; r++) hdr(8'd5, 8'd0, 8'(r), 8'd2);
    idx_pulse();
    for (int r = 1; r <= 8; r++) hdr(8'd5, 8'd0, 8'(r), 8'd2);
    idx_pulse();
    rq.push_back('{3'd1, 1'b0, cyc});
    wait_idle();

    // Header found but no sync inside the gap window, twice.
    start(8'd7, 8'd1, 8'd4);
    repeat (2) begin
      hdr(8'd7, 8'd1, 8'd4, 8'd1);
      repeat (GAP_BYTES) send_byte(8'($urandom), 1'b1);
    end
    idx_pulse();
    idx_pulse();
    rq.push_back('{3'd2, 1'b0, cyc});
    wait_idle();

    // Oversize ID.
    start(8'd1, 8'd0, 8'd1);
    hdr(8'd1, 8'd0, 8'd2, 8'd2);
    hdr(8'd1, 8'd0, 8'd1, 8'd4);
    rq.push_back('{3'd4, 1'b0, cyc});
    wait_idle();

    // Abort with byte 100 on the same cycle: that byte must not appear.
    start(8'd2, 8'd1, 8'd6);
    hdr(8'd2, 8'd1, 8'd6, 8'd2);
    sync_pulse();
    repeat (3) send_byte(MARK_A1, 1'b0);
    send_byte(MARK_FB, 1'b0);
    for (int i = 0; i < 100; i++) begin
      i_Data = 8'($urandom);
      dq.push_back('{i_Data, 10'(i)});
      send_byte(i_Data, 1'b1);
    end
    i_Data = 8'h55; i_Valid = 1'b1; hif.i_Abort = 1'b1;
    tick();
    i_Valid = 1'b0; hif.i_Abort = 1'b0;
    rq.push_back('{3'd5, 1'b0, cyc});
    repeat (5) send_byte(8'($urandom), 1'b0);
    wait_idle();

    // Abort while idle does nothing.
    hif.i_Abort = 1'b1; tick(); hif.i_Abort = 1'b0;
    tick();

`ifdef SECTOR_READ_DELETED_EN
    read_sector(8'd3, 8'd0, 8'd2, 1, 10, 1'b0, MARK_F8, 1'b0);
`else
    start(8'd3, 8'd0, 8'd2);
    hdr(8'd3, 8'd0, 8'd2, 8'd1);
    sync_pulse();
    repeat (3) send_byte(MARK_A1, 1'b0);
    send_byte(MARK_F8, 1'b0);
    repeat (20) send_byte(8'($urandom), 1'b1);
    idx_pulse();
    idx_pulse();
    rq.push_back('{3'd2, 1'b0, cyc});
    wait_idle();
`endif

    repeat (6)
      read_sector(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, GAP_BYTES - 1)), 1'($urandom_range(0, 1)),
                  MARK_FB, 1'($urandom_range(0, 1)));

    // Reset mid-read: no completion, outputs back to zero, then a clean read.
    start(8'd4, 8'd0, 8'd4);
    hdr(8'd4, 8'd0, 8'd4, 8'd0);
    sync_pulse();
    send_byte(MARK_A1, 1'b0);
    i_Reset = 1'b1; tick(); tick(); i_Reset = 1'b0;
    check_reset_state("reset_midop");
    tick();
    read_sector(8'd4, 8'd0, 8'd4, 0, 5, 1'b0, MARK_FB, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
